// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: definitions shared by the instruction-memory loader.
//   IMEM_ADDR_W   : instruction memory address width (matches the 5-bit pc)
//   DEF_SYNC_BYTE : default frame start marker
//   DEF_TIMEOUT   : default idle-cycle limit between bytes inside a frame
//   state_t       : loader FSM states
package imem_loader_pkg;

  localparam int         IMEM_ADDR_W   = 5;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         DEF_TIMEOUT   = 50000;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    BYTES,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout: idle-cycle counter for the frame receiver.
//   CLOCK_50 : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   clr      : clear the count (takes priority over en)
//   en       : count one cycle
//   expired  : count has reached TIMEOUT-1
module loader_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  // Saturates at TIMEOUT-1; the owner acts on expired in that cycle.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a program into instruction memory from a byte stream
// and holds the processor until a frame has loaded and verified cleanly.
// Frame: SYNC_BYTE, N (words), 4N data bytes (little-endian), XOR checksum
// (checksum = N ^ all data bytes).
//   CLOCK_50     : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   rx_data      : incoming byte
//   rx_valid     : rx_data valid
//   rx_ready     : loader accepts a byte (transfer = rx_valid & rx_ready)
//   imem_we      : instruction memory write enable, one cycle per word
//   imem_addr    : write address
//   imem_wdata   : write data
//   cpu_hold     : processor held while high
//   done         : last frame loaded and verified
//   error        : last frame rejected
//   words_loaded : words of the current/last frame written so far
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int         TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int LW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_nx;
  logic [LW-1:0]     len_q, len_nx;
  logic [LW-1:0]     cnt_q, cnt_nx;
  logic [1:0]        bidx_q, bidx_nx;
  logic [7:0]        csum_q, csum_nx;
  logic [31:0]       word_q, word_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [31:0]       wdata_q, wdata_nx;

  logic accept;
  logic to_active;
  logic to_clr;
  logic to_en;
  logic to_expired;

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .clr      (to_clr),
    .en       (to_en),
    .expired  (to_expired)
  );

  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = cnt_q;

  always_comb begin
    state_nx = state_q;
    len_nx   = len_q;
    cnt_nx   = cnt_q;
    bidx_nx  = bidx_q;
    csum_nx  = csum_q;
    word_nx  = word_q;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;

    rx_ready = rst_n && (state_q != WRITE);
    imem_we  = (state_q == WRITE);
    cpu_hold = (state_q != DONE);
    done     = (state_q == DONE);
    error    = (state_q == ERR);
    accept   = rx_valid && rx_ready;

    // The idle counter only matters while a frame is in flight; it is
    // frozen during the write cycle and cleared everywhere else.
    to_active = (state_q inside {LEN, BYTES, CSUM});
    to_en     = to_active;
    to_clr    = accept || !(to_active || (state_q == WRITE));

    unique case (state_q)
      IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_nx = LEN;
      end
      LEN: begin
        if (accept) begin
          if ((rx_data == 8'd0) || (int'(rx_data) > DEPTH)) begin
            state_nx = ERR;
          end else begin
            len_nx   = LW'(rx_data);
            csum_nx  = rx_data;
            cnt_nx   = '0;
            bidx_nx  = '0;
            state_nx = BYTES;
          end
        end
      end
      BYTES: begin
        if (accept) begin
          word_nx[{bidx_q, 3'b000} +: 8] = rx_data;
          csum_nx = csum_q ^ rx_data;
          bidx_nx = bidx_q + 2'd1;
          // Last byte of the word: capture address and data so they stay
          // on the memory port after the write cycle.
          if (bidx_q == 2'd3) begin
            addr_nx  = cnt_q[ADDR_W-1:0];
            wdata_nx = word_nx;
            state_nx = WRITE;
          end
        end
      end
      WRITE: begin
        cnt_nx   = cnt_q + LW'(1);
        bidx_nx  = '0;
        state_nx = (cnt_q == (len_q - LW'(1))) ? CSUM : BYTES;
      end
      CSUM: begin
        if (accept) state_nx = (rx_data == csum_q) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (accept && (rx_data == SYNC_BYTE)) state_nx = LEN;
      end
      default: state_nx = IDLE;
    endcase

    // A byte in the same cycle keeps the frame alive.
    if (to_active && to_expired && !accept) state_nx = ERR;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      bidx_q  <= bidx_nx;
      csum_q  <= csum_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
    end
  end

  // Frame length and word assembly are always rewritten before use.
  always_ff @(posedge CLOCK_50) begin
    len_q  <= len_nx;
    word_q <= word_nx;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: frame-level reference model, per-cycle
// compare of the write port and handshake, status checks per frame.
module tb_imem_loader;

  localparam int TO = 64;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       imem_we;
  logic [4:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [5:0] words_loaded;

  imem_loader #(
    .ADDR_W    (5),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TO)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int wr_cycle = -1;
  int wl_model = 0;

  logic [7:0]  fr[$];   // bytes of the frame under test
  bit          fl[$];   // byte completes a word -> write cycle follows
  int          gp[$];   // idle cycles before each byte
  logic [36:0] expq[$]; // expected writes {addr, data}

  bit          m_ok, m_bad;
  bit          ew_c;
  logic [36:0] e_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Per-cycle compare of handshake and write port against the model.
  always @(negedge CLOCK_50) begin
    if (rst_n) begin
      ew_c = (wr_cycle == cyc);
      chk("imem_we", imem_we, ew_c);
      chk("rx_ready", rx_ready, !ew_c);
      chk("cpu_hold_vs_done", cpu_hold, !done);
      chk("done_and_error", done & error, 0);
      if (imem_we) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", imem_we, 0);
        end else begin
          e_c = expq.pop_front();
          chk("imem_addr", imem_addr, e_c[36:32]);
          chk("imem_wdata", imem_wdata, e_c[31:0]);
        end
      end
    end
  end

  // Frame-level model: skip non-SYNC bytes, validate N, assemble words,
  // XOR checksum over N and data. Frame must be complete.
  task automatic model_frame(output bit ok, output bit bad);
    int s, n;
    logic [7:0]  c;
    logic [31:0] w;
    fl.delete();
    foreach (fr[i]) fl.push_back(1'b0);
    ok = 0;
    bad = 0;
    s = 0;
    while (s < fr.size() && fr[s] != 8'hA5) s++;
    if (s + 1 >= fr.size()) return;
    n = int'(fr[s+1]);
    if (n == 0 || n > 32) begin
      bad = 1;
      return;
    end
    c = fr[s+1];
    for (int k = 0; k < n; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        w[8*j +: 8] = fr[s+2+4*k+j];
        c = c ^ fr[s+2+4*k+j];
      end
      fl[s+5+4*k] = 1'b1;
      expq.push_back({5'(k), w});
    end
    wl_model = n;
    if (fr[s+2+4*n] == c) ok = 1;
    else bad = 1;
  endtask

  task automatic drive(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bit got;
      int budget;
      if (gp[i] > 0) begin
        rx_valid = 1'b0;
        repeat (gp[i]) begin
          @(posedge CLOCK_50);
          #1;
        end
      end
      rx_valid = 1'b1;
      rx_data  = fr[i];
      got      = 1'b0;
      budget   = 0;
      while (!got && budget < 16) begin
        @(negedge CLOCK_50);
        got = rx_ready;
        @(posedge CLOCK_50);
        #1;
        budget++;
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL handshake: byte %0d not accepted within 16 cycles", i);
        rx_valid = 1'b0;
        return;
      end
      if (fl[i]) wr_cycle = cyc;
    end
    rx_valid = 1'b0;
  endtask

  task automatic fill_gaps(input int gmax);
    gp.delete();
    foreach (fr[i]) gp.push_back(gmax == 0 ? 0 : int'($urandom_range(gmax, 0)));
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_done"}, done, m_ok);
    chk({tag, "_error"}, error, m_bad);
    chk({tag, "_cpu_hold"}, cpu_hold, !m_ok);
    chk({tag, "_words_loaded"}, words_loaded, wl_model);
  endtask

  task automatic run_frame(input string tag, input int gmax);
    model_frame(m_ok, m_bad);
    fill_gaps(gmax);
    drive(0, fr.size());
    check_status(tag);
  endtask

  task automatic build(input int n, input bit good, input int ngarb);
    logic [7:0] c, b;
    fr.delete();
    for (int i = 0; i < ngarb; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      fr.push_back(b);
    end
    fr.push_back(8'hA5);
    fr.push_back(8'(n));
    if (n >= 1 && n <= 32) begin
      c = 8'(n);
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        fr.push_back(b);
        c = c ^ b;
      end
      fr.push_back(good ? c : (c ^ 8'h01));
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_words_loaded"}, words_loaded, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_imem_wdata"}, imem_wdata, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    @(posedge CLOCK_50);
    #1;

    // Clean load; checksum 0x02^0x13^0x10^0x93^0x20 = 0xB2.
    fr = {8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB2};
    model_frame(m_ok, m_bad);
    chk("model_w0", expq[0], {5'd0, 32'h00100013});
    chk("model_w1", expq[1], {5'd1, 32'h00200093});
    chk("model_clean_ok", m_ok, 1);
    fill_gaps(0);
    drive(0, fr.size());
    check_status("clean");
    chk("clean_done_lit", done, 1);
    chk("clean_hold_lit", cpu_hold, 0);
    chk("clean_wl_lit", words_loaded, 2);

    // Bad checksum, also exercising reload from DONE.
    fr = {8'hA5, 8'h02, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'hB1};
    model_frame(m_ok, m_bad);
    chk("model_badsum", m_bad, 1);
    fill_gaps(0);
    drive(0, 1);
    chk("reload_hold", cpu_hold, 1);
    chk("reload_done", done, 0);
    drive(1, fr.size());
    check_status("badsum");
    chk("badsum_error_lit", error, 1);

    // Length bounds.
    fr = {8'hA5, 8'h00};
    run_frame("n0", 2);
    chk("n0_error_lit", error, 1);
    fr = {8'hA5, 8'd33};
    run_frame("n33", 2);
    chk("n33_error_lit", error, 1);
    build(32, 1'b1, 0);
    run_frame("n32", 0);
    chk("n32_done_lit", done, 1);
    chk("n32_wl_lit", words_loaded, 32);

    // Timeout expiry after A5 01 11.
    fr = {8'hA5, 8'h01, 8'h11};
    fl = {1'b0, 1'b0, 1'b0};
    gp = {0, 0, 0};
    drive(0, 3);
    wl_model = 0;
    repeat (TO - 1) @(posedge CLOCK_50);
    #1;
    chk("to_not_yet", error, 0);
    @(posedge CLOCK_50);
    #1;
    chk("to_expired", error, 1);
    chk("to_hold", cpu_hold, 1);
    chk("to_wl", words_loaded, 0);

    // Byte on the final idle cycle keeps the frame alive.
    fr = {8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    model_frame(m_ok, m_bad);
    chk("model_survive_ok", m_ok, 1);
    gp = {0, 0, 0, TO - 1, 0, 0, 0};
    drive(0, fr.size());
    check_status("to_survive");

    // Reset in the middle of a word: no write, outputs at reset values.
    fr = {8'hA5, 8'h02, 8'h13, 8'h00, 8'h10};
    fl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    gp = {0, 0, 0, 0, 0};
    drive(0, 5);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(posedge CLOCK_50);
    #1;
    reset_checks("midrst");
    rx_valid = 1'b0;
    rst_n    = 1'b1;
    wl_model = 0;
    @(posedge CLOCK_50);
    #1;

    // Randomized frames.
    for (int f = 0; f < 24; f++) begin
      int sel, n;
      sel = int'($urandom_range(9, 0));
      if (sel == 0) n = 0;
      else if (sel == 1) n = int'($urandom_range(40, 33));
      else if (sel == 2) n = 32;
      else n = int'($urandom_range(8, 1));
      build(n, ($urandom_range(3, 0) != 0), int'($urandom_range(2, 0)));
      run_frame("rnd", (f % 2 == 1) ? 3 : 0);
    end

    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("pending_writes", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
